// File: rtl/cmem_arb.sv
// Coefficient memory arbiter: shares one single-port coefficient RAM between a
// host port (single read/write accesses) and a FIR coefficient sweeper that
// reads addresses 0..ntaps_m1 back to back.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   host_*              host request/grant, write data, read data/valid
//   fir_start, ntaps_m1 sweep request and tap count minus one
//   fir_*               sweep status and coefficient stream
//   mem_*               RAM control (registered), mem_q read data
module cmem_arb #(
  parameter int unsigned AW = 6,
  parameter int unsigned DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          host_req,
  input  logic          host_wr,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_gnt,
  output logic          host_rvalid,
  output logic [DW-1:0] host_rdata,
  input  logic          fir_start,
  input  logic [AW-1:0] ntaps_m1,
  output logic          fir_busy,
  output logic          fir_coef_valid,
  output logic [DW-1:0] fir_coef,
  output logic [AW-1:0] fir_tap_idx,
  output logic          fir_done,
  output logic          mem_cen,
  output logic          mem_wen,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_d,
  input  logic [DW-1:0] mem_q
);

  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN} state_t;

  state_t        state, state_nx;
  logic [AW-1:0] cnt, cnt_nx;
  logic          pending, pending_nx;
  logic          host_pri, host_pri_nx;
  logic          mem_cen_nx, mem_wen_nx;
  logic [AW-1:0] mem_a_nx;
  logic [DW-1:0] mem_d_nx;
  logic          host_gnt_nx, host_rvalid_nx;
  logic          fir_coef_valid_nx, fir_done_nx, fir_busy_nx;
  logic [AW-1:0] fir_tap_idx_nx;
  logic          start_req;
  logic          host_win;

  // RAM read data arrives one cycle after the read edge, which is exactly the
  // cycle the matching valid flag is up, so both data outputs pass it through.
  assign fir_coef   = mem_q;
  assign host_rdata = mem_q;

  assign start_req = fir_start | pending;

  // Next-state, arbitration and RAM command generation
  always_comb begin
    state_nx          = state;
    cnt_nx            = cnt;
    pending_nx        = pending;
    host_pri_nx       = host_pri;
    mem_cen_nx        = 1'b1;
    mem_wen_nx        = 1'b1;
    mem_a_nx          = mem_a;
    mem_d_nx          = mem_d;
    host_gnt_nx       = 1'b0;
    host_rvalid_nx    = host_gnt & mem_wen;
    fir_coef_valid_nx = 1'b0;
    fir_done_nx       = 1'b0;
    fir_tap_idx_nx    = fir_tap_idx;
    host_win          = 1'b0;

    unique case (state)
      IDLE: begin
        // host wins if it has priority after a sweep, or nothing else wants the RAM
        host_win = host_req & (host_pri | ~start_req);
        if (host_win) begin
          host_gnt_nx = 1'b1;
          mem_cen_nx  = 1'b0;
          mem_wen_nx  = ~host_wr;
          mem_a_nx    = host_addr;
          mem_d_nx    = host_wdata;
          host_pri_nx = 1'b0;
          // a losing start is remembered rather than dropped
          pending_nx  = start_req;
        end else if (start_req) begin
          state_nx   = SWEEP;
          cnt_nx     = ntaps_m1;
          pending_nx = 1'b0;
          mem_cen_nx = 1'b0;
          mem_a_nx   = '0;
        end
      end
      SWEEP: begin
        fir_coef_valid_nx = 1'b1;
        fir_tap_idx_nx    = mem_a;
        if (fir_start) pending_nx = 1'b1;
        if (mem_a == cnt) begin
          state_nx    = DRAIN;
          fir_done_nx = 1'b1;
          host_pri_nx = 1'b1;
        end else begin
          mem_cen_nx = 1'b0;
          mem_a_nx   = mem_a + AW'(1);
        end
      end
      DRAIN: begin
        state_nx = IDLE;
        if (fir_start) pending_nx = 1'b1;
      end
      default: state_nx = IDLE;
    endcase

    fir_busy_nx = (state_nx != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      pending        <= 1'b0;
      host_pri       <= 1'b0;
      mem_cen        <= 1'b1;
      mem_wen        <= 1'b1;
      mem_a          <= '0;
      mem_d          <= '0;
      host_gnt       <= 1'b0;
      host_rvalid    <= 1'b0;
      fir_coef_valid <= 1'b0;
      fir_done       <= 1'b0;
      fir_busy       <= 1'b0;
      fir_tap_idx    <= '0;
    end else begin
      state          <= state_nx;
      cnt            <= cnt_nx;
      pending        <= pending_nx;
      host_pri       <= host_pri_nx;
      mem_cen        <= mem_cen_nx;
      mem_wen        <= mem_wen_nx;
      mem_a          <= mem_a_nx;
      mem_d          <= mem_d_nx;
      host_gnt       <= host_gnt_nx;
      host_rvalid    <= host_rvalid_nx;
      fir_coef_valid <= fir_coef_valid_nx;
      fir_done       <= fir_done_nx;
      fir_busy       <= fir_busy_nx;
      fir_tap_idx    <= fir_tap_idx_nx;
    end
  end

endmodule

// File: tb/tb_cmem_arb.sv
// Self-checking bench for cmem_arb: RAM model, host request queue, and a
// transaction-level reference model compared against the DUT every cycle.
module tb_cmem_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        host_req, host_wr;
  logic [5:0]  host_addr;
  logic [15:0] host_wdata;
  logic        host_gnt, host_rvalid;
  logic [15:0] host_rdata;
  logic        fir_start;
  logic [5:0]  ntaps_m1;
  logic        fir_busy, fir_coef_valid, fir_done;
  logic [15:0] fir_coef;
  logic [5:0]  fir_tap_idx;
  logic        mem_cen, mem_wen;
  logic [5:0]  mem_a;
  logic [15:0] mem_d, mem_q;

  cmem_arb #(.AW(6), .DW(16)) dut (
    .clk(clk), .rst(rst),
    .host_req(host_req), .host_wr(host_wr), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_gnt(host_gnt), .host_rvalid(host_rvalid),
    .host_rdata(host_rdata), .fir_start(fir_start), .ntaps_m1(ntaps_m1),
    .fir_busy(fir_busy), .fir_coef_valid(fir_coef_valid), .fir_coef(fir_coef),
    .fir_tap_idx(fir_tap_idx), .fir_done(fir_done), .mem_cen(mem_cen),
    .mem_wen(mem_wen), .mem_a(mem_a), .mem_d(mem_d), .mem_q(mem_q)
  );

  always #5 clk = ~clk;

  // Single-port RAM with one-cycle read latency
  logic [15:0] ram [64];
  always @(posedge clk) begin
    if (!mem_cen) begin
      if (!mem_wen) ram[mem_a] <= mem_d;
      else          mem_q <= ram[mem_a];
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {logic wr; logic [5:0] addr; logic [15:0] data;} hop_t;
  hop_t hq[$];

  logic [15:0] ref_mem [64];
  int   phase, p, n;            // phase: 0 idle, 1 reading tap p, 2 drain
  bit   m_pend, m_pri, rd_next;
  logic [5:0] rd_addr;
  logic e_gnt, e_rv, e_cv, e_done, e_busy, e_cen, e_wen;
  logic [15:0] e_rdata, e_cdata, e_d;
  logic [5:0]  e_idx, e_a;

  // statistics for directed scenarios
  int cycle = 0;
  logic [15:0] coef_q[$];
  logic [5:0]  idx_q[$];
  int done_cnt, busy_cyc, rises, rise_cyc, gnt_cyc;
  logic [5:0]  done_idx;
  logic [15:0] last_rdata;
  bit busy_prev;

  task automatic clear_stats();
    coef_q.delete(); idx_q.delete();
    done_cnt = 0; busy_cyc = 0; rises = 0; rise_cyc = -1; gnt_cyc = -1;
    done_idx = '0; last_rdata = '0;
  endtask

  always @(negedge clk) begin
    cycle++;
    if (rst) begin
      phase = 0; p = 0; n = 0; m_pend = 0; m_pri = 0; rd_next = 0;
      e_gnt = 0; e_rv = 0; e_cv = 0; e_done = 0; e_busy = 0;
      e_cen = 1; e_wen = 1; busy_prev = 0;
      chk("rst_mem_a", 32'(mem_a), 32'd0);
      chk("rst_mem_d", 32'(mem_d), 32'd0);
      chk("rst_tap_idx", 32'(fir_tap_idx), 32'd0);
    end
    chk("host_gnt", 32'(host_gnt), 32'(e_gnt));
    chk("host_rvalid", 32'(host_rvalid), 32'(e_rv));
    if (e_rv) chk("host_rdata", 32'(host_rdata), 32'(e_rdata));
    chk("coef_valid", 32'(fir_coef_valid), 32'(e_cv));
    if (e_cv) begin
      chk("coef", 32'(fir_coef), 32'(e_cdata));
      chk("tap_idx", 32'(fir_tap_idx), 32'(e_idx));
    end
    chk("fir_done", 32'(fir_done), 32'(e_done));
    chk("fir_busy", 32'(fir_busy), 32'(e_busy));
    chk("mem_cen", 32'(mem_cen), 32'(e_cen));
    chk("mem_wen", 32'(mem_wen), 32'(e_wen));
    if (!e_cen) chk("mem_a", 32'(mem_a), 32'(e_a));
    if (!e_cen && !e_wen) chk("mem_d", 32'(mem_d), 32'(e_d));

    if (!rst) begin
      if (fir_coef_valid) begin coef_q.push_back(fir_coef); idx_q.push_back(fir_tap_idx); end
      if (fir_done) begin done_cnt++; done_idx = fir_tap_idx; end
      if (fir_busy) busy_cyc++;
      if (fir_busy && !busy_prev) begin rises++; rise_cyc = cycle; end
      busy_prev = fir_busy;
      if (host_gnt) gnt_cyc = cycle;
      if (host_rvalid) last_rdata = host_rdata;

      // predict outputs after the coming rising edge
      e_rv = rd_next; e_rdata = ref_mem[rd_addr]; rd_next = 0;
      e_gnt = 0; e_cen = 1; e_wen = 1; e_cv = 0; e_done = 0;
      case (phase)
        0: begin
          if (host_req && (m_pri || !(fir_start || m_pend))) begin
            e_gnt = 1; e_cen = 0; e_wen = !host_wr; e_a = host_addr; e_d = host_wdata;
            m_pri = 0;
            if (fir_start) m_pend = 1;
            if (host_wr) ref_mem[host_addr] = host_wdata;
            else begin rd_next = 1; rd_addr = host_addr; end
          end else if (fir_start || m_pend) begin
            phase = 1; p = 0; n = int'(ntaps_m1); m_pend = 0;
            e_cen = 0; e_a = 6'd0;
          end
        end
        1: begin
          e_cv = 1; e_idx = 6'(p); e_cdata = ref_mem[p];
          if (fir_start) m_pend = 1;
          if (p == n) begin phase = 2; e_done = 1; m_pri = 1; end
          else begin p++; e_cen = 0; e_a = 6'(p); end
        end
        default: begin
          phase = 0;
          if (fir_start) m_pend = 1;
        end
      endcase
      e_busy = (phase != 0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive_host();
    if (hq.size() != 0) begin
      host_req = 1'b1; host_wr = hq[0].wr; host_addr = hq[0].addr; host_wdata = hq[0].data;
    end else begin
      host_req = 1'b0;
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
    if (host_gnt && hq.size() != 0) void'(hq.pop_front());
    drive_host();
  endtask

  task automatic push(input logic wr, input logic [5:0] a, input logic [15:0] d);
    hop_t h;
    h.wr = wr; h.addr = a; h.data = d;
    hq.push_back(h);
    drive_host();
  endtask

  task automatic start_sweep(input logic [5:0] nm1);
    fir_start = 1'b1; ntaps_m1 = nm1;
    cyc();
    fir_start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int limit);
    int k = 0;
    int quiet = 0;
    while (quiet < 3 && k < limit) begin
      cyc(); k++;
      if (!fir_busy && hq.size() == 0 && !host_gnt) quiet++; else quiet = 0;
    end
    if (k >= limit) chk({name, "_timeout"}, 32'(k), 32'(limit - 1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k;
    rst = 1'b1; host_req = 0; host_wr = 0; host_addr = 0; host_wdata = 0;
    fir_start = 0; ntaps_m1 = 0;
    clear_stats();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_cen", 32'(mem_cen), 32'd1);
    chk("reset_wen", 32'(mem_wen), 32'd1);
    chk("reset_busy", 32'(fir_busy), 32'd0);
    chk("reset_gnt", 32'(host_gnt), 32'd0);
    rst = 1'b0;

    // fill the whole RAM with back-to-back host writes
    for (int i = 0; i < 64; i++) push(1'b1, 6'(i), 16'($urandom));
    wait_idle("preload", 200);

    // host write then read of the same word
    clear_stats();
    push(1'b1, 6'd4, 16'd4001);
    push(1'b0, 6'd4, 16'd0);
    wait_idle("wr_rd", 50);
    chk("wr_rd_data", 32'(last_rdata), 32'd4001);

    // four-tap sweep over known coefficients
    for (int i = 0; i < 4; i++) push(1'b1, 6'(i), 16'(10 * (i + 1)));
    wait_idle("preload4", 50);
    clear_stats();
    start_sweep(6'd3);
    wait_idle("sweep4", 50);
    chk("sweep4_count", 32'(coef_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < coef_q.size(); i++) begin
      chk("sweep4_coef", 32'(coef_q[i]), 32'(10 * (i + 1)));
      chk("sweep4_idx", 32'(idx_q[i]), 32'(i));
    end
    chk("sweep4_done", 32'(done_cnt), 32'd1);
    chk("sweep4_done_idx", 32'(done_idx), 32'd3);
    chk("sweep4_busy", 32'(busy_cyc), 32'd5);

    // host held through a sweep, start re-requested in the first idle cycle
    clear_stats();
    start_sweep(6'd2);
    push(1'b0, 6'd2, 16'd0);
    k = 0;
    while (fir_busy && k < 50) begin cyc(); k++; end
    chk("contend_host_stalled", 32'(hq.size()), 32'd1);
    start_sweep(6'd1);
    wait_idle("contend", 50);
    chk("contend_gnt_seen", 32'(gnt_cyc > 0), 32'd1);
    chk("contend_order", 32'(rise_cyc), 32'(gnt_cyc + 1));
    chk("contend_rdata", 32'(last_rdata), 32'd30);

    // three starts during one sweep coalesce into one extra sweep
    clear_stats();
    start_sweep(6'd7);
    for (int i = 0; i < 3; i++) begin start_sweep(6'd1); cyc(); end
    wait_idle("coalesce", 80);
    chk("coalesce_sweeps", 32'(rises), 32'd2);
    chk("coalesce_dones", 32'(done_cnt), 32'd2);

    // single-tap sweep
    clear_stats();
    start_sweep(6'd0);
    wait_idle("one_tap", 30);
    chk("one_tap_count", 32'(coef_q.size()), 32'd1);
    chk("one_tap_done", 32'(done_cnt), 32'd1);
    chk("one_tap_idx", 32'(done_idx), 32'd0);
    chk("one_tap_coef", 32'(coef_q.size() > 0 ? coef_q[0] : 16'hffff), 32'd10);

    // full-depth sweep with no wrap
    clear_stats();
    start_sweep(6'd63);
    wait_idle("full", 120);
    chk("full_count", 32'(coef_q.size()), 32'd64);
    chk("full_last_idx", 32'(idx_q.size() == 64 ? idx_q[63] : 6'd0), 32'd63);
    chk("full_busy", 32'(busy_cyc), 32'd65);

    // reset while tap 2 is on the output
    clear_stats();
    start_sweep(6'd5);
    k = 0;
    while (!(fir_coef_valid && fir_tap_idx == 6'd2) && k < 30) begin cyc(); k++; end
    chk("midrst_reached_tap2", 32'(k < 30), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("midrst_cen", 32'(mem_cen), 32'd1);
    chk("midrst_busy", 32'(fir_busy), 32'd0);
    chk("midrst_valid", 32'(fir_coef_valid), 32'd0);
    chk("midrst_idx", 32'(fir_tap_idx), 32'd0);
    chk("midrst_mem_a", 32'(mem_a), 32'd0);
    cyc();
    rst = 1'b0;
    chk("midrst_no_done", 32'(done_cnt), 32'd0);
    clear_stats();
    start_sweep(6'd2);
    chk("restart_addr", 32'(mem_a), 32'd0);
    chk("restart_cen", 32'(mem_cen), 32'd0);
    wait_idle("restart", 30);
    chk("restart_first_idx", 32'(idx_q.size() > 0 ? idx_q[0] : 6'h3f), 32'd0);

    // random mix of host traffic and sweep requests
    for (int i = 0; i < 800; i++) begin
      fir_start = ($urandom_range(0, 11) == 0);
      ntaps_m1 = 6'($urandom_range(0, 7));
      cyc();
      if (hq.size() == 0 && $urandom_range(0, 2) == 0)
        push(1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), 16'($urandom));
    end
    fir_start = 1'b0;
    wait_idle("random", 200);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
